lsu_mem_stage: RTL



---
 rtl/lsu_mem_stage.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: issues one doubleword bus access per op and returns an extended load result.
// Optional misaligned-access trap is enabled with LSU_MISALIGN_TRAP_EN.
module lsu_mem_stage #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic              mem_r_ena,
  input  logic              mem_w_ena,
  input  logic [7:0]        byte_enable,
  input  logic              mem_ext_un,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [63:0]       ld_data,
  output logic              misalign,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [7:0]        bus_wstrb,
  output logic [63:0]       bus_wdata,
  input  logic              bus_rvalid,
  input  logic [63:0]       bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          off_q;
  logic [1:0]          size_q, size_d;
  logic                ext_q, we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          wstrb_q, strb_d;
  logic [63:0]         wdata_q, wdata_d, ld_q;
  logic                legal, accept;

  // Size is encoded as log2 of the access width in bytes.
  function automatic logic [63:0] extend_load(input logic [63:0] rd, input logic [2:0] off,
                                              input logic [1:0] sz, input logic zext);
    logic [63:0] sh;
    sh = rd >> {off, 3'b000};
    case (sz)
      2'd0:    extend_load = zext ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
      2'd1:    extend_load = zext ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    extend_load = zext ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: extend_load = sh;
    endcase
  endfunction

  always_comb begin
    legal  = 1'b1;
    size_d = 2'd0;
    case (byte_enable)
      8'h01:   size_d = 2'd0;
      8'h03:   size_d = 2'd1;
      8'h0F:   size_d = 2'd2;
      8'hFF:   size_d = 2'd3;
      default: legal  = 1'b0;
    endcase
  end

  assign accept  = (state_q == IDLE) & op_valid & (mem_r_ena | mem_w_ena) & legal;
  // Bytes shifted past the top of the doubleword fall off here.
  assign strb_d  = byte_enable << addr[2:0];
  assign wdata_d = wdata << {addr[2:0], 3'b000};

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_now, mis_q;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'd1:    is_misaligned = off[0];
      2'd2:    is_misaligned = |off[1:0];
      2'd3:    is_misaligned = |off;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  assign mis_now  = is_misaligned(size_d, addr[2:0]);
  assign misalign = (state_q == DONE) & mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      mis_q <= 1'b0;
    else if (accept) mis_q <= mis_now;
  end
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
        state_d = mis_now ? DONE : REQ;
`else
        state_d = REQ;
`endif
      end
      REQ:     if (bus_ready) state_d = we_q ? DONE : RESP;
      RESP:    if (bus_rvalid) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      off_q   <= 3'd0;
      size_q  <= 2'd0;
      ext_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= 8'h00;
      wdata_q <= 64'd0;
      ld_q    <= 64'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        off_q   <= addr[2:0];
        size_q  <= size_d;
        ext_q   <= mem_ext_un;
        we_q    <= mem_w_ena;
        addr_q  <= {addr[ADDR_W-1:3], 3'b000};
        wstrb_q <= mem_w_ena ? strb_d  : 8'h00;
        wdata_q <= mem_w_ena ? wdata_d : 64'd0;
      end
      if (state_q == RESP && bus_rvalid)
        ld_q <= extend_load(bus_rdata, off_q, size_q, ext_q);
    end
  end

  assign op_ready  = (state_q == IDLE);
  assign bus_valid = (state_q == REQ);
  assign done      = (state_q == DONE);
  assign stall     = (state_q == REQ) | (state_q == RESP) | accept;
  assign bus_addr  = addr_q;
  assign bus_we    = we_q;
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;
  assign ld_data   = ld_q;

endmodule
